pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register for the five-stage core. It succeeds the fixed-field ID/EX-style registers with a valid/ready handshake, a generic data payload and control payload, and an optional skid buffer. Stalls hold the stage instead of inserting bubbles, and flush kills everything in flight. It drops in between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 96, payload width (pc, operands, imm, register indices); held through bubbles.
CTRL_W, 24, control-signal width (RUWr, DMWR, Branch, AluOp, ...); forced to zero whenever the stage is empty.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all stage contents (branch taken / exception)
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage accepts this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
out_valid  out  1  stage holds a valid instruction
out_ready  in  1  downstream accepts (0 = stall)
out_data  out  DATA_W  registered payload
out_ctrl  out  CTRL_W  registered control; all zero when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (optional feature only)
bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1 (optional feature only)

Behaviour:
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state changes occur on the rising clk edge.
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_ctrl=0, skid entry empty and zeroed, counters=0. in_ready=1 when SKID=1.
- Priority: reset > flush > handshake.
- Flush: next cycle out_valid=0, out_ctrl=0, out_data=0, skid emptied. Any in_fire that cycle is discarded. With SKID=1, in_ready=1 the cycle after.
- SKID=0 (states EMPTY, ONE):
  - in_ready = !out_valid | out_ready (combinational).
  - EMPTY: in_fire -> ONE, load in_data/in_ctrl.
  - ONE: out_fire & in_fire -> ONE with the new load. out_fire & !in_fire -> EMPTY, out_ctrl<=0, out_data held. !out_ready -> hold all outputs.
- SKID=1 (states EMPTY, ONE, FULL):
  - in_ready is registered: 1 in EMPTY and ONE, 0 in FULL. There is no combinational path from out_ready to in_ready.
  - EMPTY: in_fire -> ONE, load main.
  - ONE: in_fire & out_fire -> ONE, load main. in_fire & !out_ready -> FULL, load skid. out_fire & !in_fire -> EMPTY, out_ctrl<=0.
  - FULL: out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid in both modes.
- Ordering: strict FIFO, no drop, no duplicate. out_data/out_ctrl are stable while out_valid & !out_ready.
- Control gating invariant: out_valid=0 implies out_ctrl=0 in every cycle.
- Reset asserted mid-transfer: all contents lost; no partial state survives.

Optional Feature:
PIPE_STAGE_PERF_EN.
- Defined: stall_cnt and bubble_cnt are present.
  - Each increments by 1 in the cycles defined under Ports, and saturates at all-ones.
  - Cleared only by reset; flush does not clear them.
  - A flush cycle itself is counted by the pre-flush state.
- Undefined: both ports are driven to constant 0 and no counter flops are synthesised.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_ctrl=all ones -> out_valid=0, out_ctrl=0, out_data=0 (SKID=1: in_ready=1). Release -> first in_fire appears on out_valid after 1 cycle.
- Streaming: SKID=1, out_ready=1, feed data 1..8 back-to-back -> outputs 1..8 on consecutive cycles, in_ready stays 1, no gaps.
- Stall/skid: SKID=1, send A, B, then out_ready=0 for 3 cycles:
  - in_ready drops the cycle after B is captured (FULL).
  - out_data=A held steady.
  - Release -> A then B, then in_ready returns to 1.
- Drain: SKID=0, send one item C with ctrl=0x00FFFF, no further input -> after out_fire, out_valid=0, out_ctrl=0, out_data still C.
- Flush: FULL state with a simultaneous in_valid=1 -> next cycle out_valid=0, out_ctrl=0, skid empty, the incoming item never appears at the output.
- Perf (PIPE_STAGE_PERF_EN, CNT_W=4):
  - 20 cycles with out_valid=1, out_ready=0 -> stall_cnt saturates at 15.
  - 5 idle cycles with out_ready=1 -> bubble_cnt=5.
  - Flush leaves both counters unchanged.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic valid/ready pipeline stage register with data and
//            control payloads and an optional two-entry skid buffer.
//            SKID=1 gives a registered in_ready. SKID=0 gives a single
//            entry with a combinational in_ready.
//            Control bits are zero whenever the stage is empty.
//            Optional feature macro: PIPE_STAGE_PERF_EN adds the
//            saturating stall/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              w_in_ready;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_out_data;
    logic [CTRL_W-1:0] w_out_ctrl;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t            r_state, w_state_nxt;
            logic [DATA_W-1:0] r_data, w_data_nxt;
            logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt;
            logic [DATA_W-1:0] r_skid_data, w_skid_data_nxt;
            logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_nxt;
            logic              r_in_ready;

            // State and payload registers; in_ready is registered from the next state
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state     <= ST_EMPTY;
                    r_data      <= '0;
                    r_ctrl      <= '0;
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                    r_in_ready  <= 1'b1;
                end else begin
                    r_state     <= w_state_nxt;
                    r_data      <= w_data_nxt;
                    r_ctrl      <= w_ctrl_nxt;
                    r_skid_data <= w_skid_data_nxt;
                    r_skid_ctrl <= w_skid_ctrl_nxt;
                    r_in_ready  <= (w_state_nxt != ST_FULL);
                end
            end

            // Next-state logic: flush beats the handshake, skid absorbs a stalled accept
            always_comb begin
                w_state_nxt     = r_state;
                w_data_nxt      = r_data;
                w_ctrl_nxt      = r_ctrl;
                w_skid_data_nxt = r_skid_data;
                w_skid_ctrl_nxt = r_skid_ctrl;
                if (flush) begin
                    w_state_nxt     = ST_EMPTY;
                    w_data_nxt      = '0;
                    w_ctrl_nxt      = '0;
                    w_skid_data_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                w_state_nxt = ST_ONE;
                                w_data_nxt  = in_data;
                                w_ctrl_nxt  = in_ctrl;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                w_data_nxt = in_data;
                                w_ctrl_nxt = in_ctrl;
                            end else if (w_in_fire) begin
                                w_state_nxt     = ST_FULL;
                                w_skid_data_nxt = in_data;
                                w_skid_ctrl_nxt = in_ctrl;
                            end else if (w_out_fire) begin
                                // payload is held through the bubble, control is not
                                w_state_nxt = ST_EMPTY;
                                w_ctrl_nxt  = '0;
                            end
                        end
                        ST_FULL: begin
                            if (w_out_fire) begin
                                w_state_nxt     = ST_ONE;
                                w_data_nxt      = r_skid_data;
                                w_ctrl_nxt      = r_skid_ctrl;
                                w_skid_data_nxt = '0;
                                w_skid_ctrl_nxt = '0;
                            end
                        end
                        default: begin
                            w_state_nxt     = ST_EMPTY;
                            w_data_nxt      = '0;
                            w_ctrl_nxt      = '0;
                            w_skid_data_nxt = '0;
                            w_skid_ctrl_nxt = '0;
                        end
                    endcase
                end
            end

            assign w_in_ready  = r_in_ready;
            assign w_out_valid = (r_state != ST_EMPTY);
            assign w_out_data  = r_data;
            assign w_out_ctrl  = r_ctrl;
        end else begin : g_noskid
            typedef enum logic {
                ST_EMPTY = 1'b0,
                ST_ONE   = 1'b1
            } state_t;

            state_t            r_state, w_state_nxt;
            logic [DATA_W-1:0] r_data, w_data_nxt;
            logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt;

            // State and payload registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_EMPTY;
                    r_data  <= '0;
                    r_ctrl  <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_data  <= w_data_nxt;
                    r_ctrl  <= w_ctrl_nxt;
                end
            end

            // Next-state logic: an accept in ONE implies the old entry left the same cycle
            always_comb begin
                w_state_nxt = r_state;
                w_data_nxt  = r_data;
                w_ctrl_nxt  = r_ctrl;
                if (flush) begin
                    w_state_nxt = ST_EMPTY;
                    w_data_nxt  = '0;
                    w_ctrl_nxt  = '0;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_data_nxt  = in_data;
                    w_ctrl_nxt  = in_ctrl;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                    w_ctrl_nxt  = '0;
                end
            end

            assign w_out_valid = (r_state == ST_ONE);
            assign w_in_ready  = !w_out_valid | out_ready;
            assign w_out_data  = r_data;
            assign w_out_ctrl  = r_ctrl;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_data;
    assign out_ctrl  = w_out_ctrl;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating stall/bubble counters; sampled from the pre-edge state so a
    // flush cycle is counted by what the stage held before it was killed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (!w_out_valid && out_ready && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg. Instance a
//            uses SKID=1 and instance b uses SKID=0. Counter expectations
//            depend on PIPE_STAGE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 24;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;

    logic              flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [DATA_W-1:0] in_data_a, out_data_a;
    logic [CTRL_W-1:0] in_ctrl_a, out_ctrl_a;
    logic [CNT_W-1:0]  stall_a, bubble_a;

    logic              flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [DATA_W-1:0] in_data_b, out_data_b;
    logic [CTRL_W-1:0] in_ctrl_b, out_ctrl_b;
    logic [CNT_W-1:0]  stall_b, bubble_b;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_ctrl(in_ctrl_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_ctrl(out_ctrl_a),
        .stall_cnt(stall_a), .bubble_cnt(bubble_a)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(CNT_W)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_ctrl(in_ctrl_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_ctrl(out_ctrl_b),
        .stall_cnt(stall_b), .bubble_cnt(bubble_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        flush_a = 1'b0; in_valid_a = 1'b1; in_data_a = 32'hDEAD_BEEF; in_ctrl_a = '1; out_ready_a = 1'b0;
        flush_b = 1'b0; in_valid_b = 1'b1; in_data_b = 32'hDEAD_BEEF; in_ctrl_b = '1; out_ready_b = 1'b0;
        #2 rst_n = 1'b0;
        tick(); tick();

        // ---- reset with in_valid and all-ones control pending ----
        check("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        check("rst_out_ctrl_a",  32'(out_ctrl_a),  32'd0);
        check("rst_out_data_a",  32'(out_data_a),  32'd0);
        check("rst_in_ready_a",  32'(in_ready_a),  32'd1);
        check("rst_out_valid_b", 32'(out_valid_b), 32'd0);
        check("rst_out_ctrl_b",  32'(out_ctrl_b),  32'd0);
        rst_n = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;

        // ---- streaming 1..8 through the skid stage ----
        out_ready_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid_a = 1'b1; in_data_a = 32'(i); in_ctrl_a = 24'(i);
            tick();
            check("stream_valid", 32'(out_valid_a), 32'd1);
            check("stream_data",  out_data_a,       32'(i));
            check("stream_ctrl",  32'(out_ctrl_a),  32'(i));
            check("stream_ready", 32'(in_ready_a),  32'd1);
        end
        in_valid_a = 1'b0;
        tick();
        check("stream_end_valid", 32'(out_valid_a), 32'd0);
        check("stream_end_ctrl",  32'(out_ctrl_a),  32'd0);
        check("stream_end_data",  out_data_a,       32'd8);

        // ---- stall into the skid buffer ----
        in_valid_a = 1'b1; in_data_a = 32'hA; in_ctrl_a = 24'h0A; out_ready_a = 1'b1;
        tick();
        check("skid_A_data",  out_data_a,      32'hA);
        check("skid_A_ready", 32'(in_ready_a), 32'd1);
        in_data_a = 32'hB; in_ctrl_a = 24'h0B; out_ready_a = 1'b0;
        tick();
        check("skid_full_ready", 32'(in_ready_a),  32'd0);
        check("skid_full_data",  out_data_a,       32'hA);
        check("skid_full_valid", 32'(out_valid_a), 32'd1);
        in_valid_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("skid_hold_data",  out_data_a,      32'hA);
            check("skid_hold_ctrl",  32'(out_ctrl_a), 32'h0A);
            check("skid_hold_ready", 32'(in_ready_a), 32'd0);
        end
        out_ready_a = 1'b1;
        tick();
        check("skid_B_valid", 32'(out_valid_a), 32'd1);
        check("skid_B_data",  out_data_a,       32'hB);
        check("skid_B_ctrl",  32'(out_ctrl_a),  32'h0B);
        check("skid_B_ready", 32'(in_ready_a),  32'd1);
        tick();
        check("skid_drain_valid", 32'(out_valid_a), 32'd0);
        check("skid_drain_ctrl",  32'(out_ctrl_a),  32'd0);

        // ---- flush while FULL with in_valid asserted ----
        in_valid_a = 1'b1; in_data_a = 32'hC1; in_ctrl_a = 24'h01; out_ready_a = 1'b1;
        tick();
        in_data_a = 32'hC2; in_ctrl_a = 24'h02; out_ready_a = 1'b0;
        tick();
        check("flush_pre_ready", 32'(in_ready_a), 32'd0);
        flush_a = 1'b1; in_data_a = 32'hC3; in_ctrl_a = 24'h03;
        tick();
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        check("flush_valid", 32'(out_valid_a), 32'd0);
        check("flush_ctrl",  32'(out_ctrl_a),  32'd0);
        check("flush_data",  out_data_a,       32'd0);
        check("flush_ready", 32'(in_ready_a),  32'd1);
        tick();
        check("flush_skid_empty", 32'(out_valid_a), 32'd0);

        // ---- flush in ONE discards a simultaneous accept ----
        in_valid_a = 1'b1; in_data_a = 32'hD1; in_ctrl_a = 24'h11;
        tick();
        flush_a = 1'b1; in_data_a = 32'hD2; in_ctrl_a = 24'h12;
        tick();
        flush_a = 1'b0; in_valid_a = 1'b0;
        check("flush_one_valid", 32'(out_valid_a), 32'd0);
        tick();
        check("flush_one_still", 32'(out_valid_a), 32'd0);

        // ---- SKID=0: drain leaves payload, clears control ----
        in_valid_b = 1'b1; in_data_b = 32'hC; in_ctrl_b = 24'h00FFFF; out_ready_b = 1'b0;
        #1;
        check("b_empty_ready", 32'(in_ready_b), 32'd1);
        tick();
        check("b_load_valid", 32'(out_valid_b), 32'd1);
        check("b_load_data",  out_data_b,       32'hC);
        check("b_load_ctrl",  32'(out_ctrl_b),  32'h00FFFF);
        in_valid_b = 1'b0;
        #1;
        check("b_stall_ready", 32'(in_ready_b), 32'd0);
        tick();
        check("b_stall_data", out_data_b, 32'hC);
        out_ready_b = 1'b1;
        #1;
        check("b_release_ready", 32'(in_ready_b), 32'd1);
        tick();
        check("b_drain_valid", 32'(out_valid_b), 32'd0);
        check("b_drain_ctrl",  32'(out_ctrl_b),  32'd0);
        check("b_drain_data",  out_data_b,       32'hC);

        // ---- SKID=0: back-to-back replacement ----
        in_valid_b = 1'b1; in_data_b = 32'hD; in_ctrl_b = 24'h0D;
        tick();
        in_data_b = 32'hE; in_ctrl_b = 24'h0E;
        tick();
        check("b_b2b_data", out_data_b,      32'hE);
        check("b_b2b_ctrl", 32'(out_ctrl_b), 32'h0E);
        in_valid_b = 1'b0;
        tick();
        check("b_b2b_end_valid", 32'(out_valid_b), 32'd0);
        check("b_b2b_end_data",  out_data_b,       32'hE);

        // ---- asynchronous reset while the skid stage is FULL ----
        in_valid_a = 1'b1; in_data_a = 32'hF1; in_ctrl_a = 24'h21; out_ready_a = 1'b1;
        tick();
        in_data_a = 32'hF2; out_ready_a = 1'b0;
        tick();
        in_valid_a = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid_a), 32'd0);
        check("midrst_data",  out_data_a,       32'd0);
        check("midrst_ctrl",  32'(out_ctrl_a),  32'd0);
        check("midrst_ready", 32'(in_ready_a),  32'd1);
        tick();
        rst_n = 1'b1;
        out_ready_a = 1'b0;
        tick();
        check("midrst_after_valid", 32'(out_valid_a), 32'd0);
        check("midrst_stall",  32'(stall_a),  32'd0);
        check("midrst_bubble", 32'(bubble_a), 32'd0);

        // ---- performance counters ----
        out_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_valid_a = 1'b1; in_data_a = 32'h77; in_ctrl_a = 24'h77; out_ready_a = 1'b0;
        tick();
        in_valid_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall_10", 32'(stall_a), 32'd10);
`else
        check("perf_stall_off", 32'(stall_a), 32'd0);
`endif
        for (int i = 0; i < 10; i++) tick();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall_sat",    32'(stall_a),  32'd15);
        check("perf_bubble_5",     32'(bubble_a), 32'd5);
`else
        check("perf_stall_off2",   32'(stall_a),  32'd0);
        check("perf_bubble_off",   32'(bubble_a), 32'd0);
`endif
        check("perf_flush_valid", 32'(out_valid_a), 32'd0);
        tick();
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall_kept",  32'(stall_a),  32'd15);
        check("perf_bubble_kept", 32'(bubble_a), 32'd5);
`else
        check("perf_bubble_off2", 32'(bubble_a), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
